// File: rtl/req_enc_pkg.sv
// Shared constants, state encoding and helpers for the request capture/encode front end.
// Round-robin selection is enabled by defining REQ_ENC_ROUND_ROBIN_EN.
package req_enc_pkg;

  localparam int unsigned NUM_REQ = 8;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned CNT_W   = 8;

  typedef enum logic [0:0] {
    StIdle    = 1'b0,
    StPresent = 1'b1
  } state_e;

  function automatic logic [IDX_W:0] popcount(input logic [NUM_REQ-1:0] v);
    logic [IDX_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt = cnt + {{IDX_W{1'b0}}, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/pri_encoder_core.sv
// Combinational selector over the pending vector: fixed highest-index priority, or
// round-robin from start_i when REQ_ENC_ROUND_ROBIN_EN is defined.
module pri_encoder_core
  import req_enc_pkg::*;
(
  input  logic [NUM_REQ-1:0] pending_i,
`ifdef REQ_ENC_ROUND_ROBIN_EN
  input  logic [IDX_W-1:0]   start_i,
`endif
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

`ifdef REQ_ENC_ROUND_ROBIN_EN
  logic [IDX_W-1:0] cand;

  // Walk offsets from far to near so the nearest set bit above start_i wins.
  always_comb begin
    idx_o = '0;
    cand  = '0;
    any_o = |pending_i;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = start_i + IDX_W'(i);
      if (pending_i[cand]) begin
        idx_o = cand;
      end
    end
  end
`else
  // Later iterations overwrite earlier ones, so the highest set index wins.
  always_comb begin
    idx_o = '0;
    any_o = |pending_i;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pending_i[i]) begin
        idx_o = IDX_W'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/req_capture_encoder.sv
// Captures request rising edges into a pending set and hands out one code per valid/ready
// transaction. Define REQ_ENC_ROUND_ROBIN_EN for round-robin instead of fixed priority.
module req_capture_encoder
  import req_enc_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               flush_i,
  input  logic               ready_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   code_o,
  output logic               any_pending_o,
  output logic               lost_o,
  output logic [CNT_W-1:0]   drop_cnt_o
);

  logic [NUM_REQ-1:0] req_q;
  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic               valid_q, valid_d;
  logic [IDX_W-1:0]   code_q, code_d;
  logic               lost_q, lost_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  state_e             state_q, state_d;

  logic [NUM_REQ-1:0] edges;
  logic [NUM_REQ-1:0] clr;
  logic [NUM_REQ-1:0] lost_bits;
  logic               handshake;
  logic [CNT_W:0]     drop_sum;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_any;

`ifdef REQ_ENC_ROUND_ROBIN_EN
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
`endif

  assign edges     = req_i & ~req_q;
  assign handshake = valid_q & ready_i;
  assign clr       = handshake ? (NUM_REQ'(1) << code_q) : '0;
  // A clear in the same cycle absorbs the edge (set wins), so it is not a loss.
  assign lost_bits = edges & pending_q & ~clr;
  assign drop_sum  = {1'b0, drop_cnt_q} + (CNT_W + 1)'(popcount(lost_bits));

  pri_encoder_core u_pri_encoder_core (
    .pending_i (pending_q),
`ifdef REQ_ENC_ROUND_ROBIN_EN
    .start_i   (last_grant_q + IDX_W'(1)),
`endif
    .idx_o     (sel_idx),
    .any_o     (sel_any)
  );

  always_comb begin
    pending_d  = pending_q;
    valid_d    = valid_q;
    code_d     = code_q;
    lost_d     = 1'b0;
    drop_cnt_d = drop_cnt_q;
    state_d    = state_q;
`ifdef REQ_ENC_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    if (flush_i) begin
      pending_d = '0;
      valid_d   = 1'b0;
      state_d   = StIdle;
    end else begin
      pending_d  = (pending_q & ~clr) | edges;
      lost_d     = |lost_bits;
      drop_cnt_d = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
      case (state_q)
        StIdle: begin
          if (sel_any) begin
            code_d  = sel_idx;
            valid_d = 1'b1;
            state_d = StPresent;
          end
        end
        StPresent: begin
          if (handshake) begin
            valid_d = 1'b0;
            state_d = StIdle;
`ifdef REQ_ENC_ROUND_ROBIN_EN
            last_grant_d = code_q;
`endif
          end
        end
        default: begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q      <= '0;
      pending_q  <= '0;
      valid_q    <= 1'b0;
      code_q     <= '0;
      lost_q     <= 1'b0;
      drop_cnt_q <= '0;
      state_q    <= StIdle;
    end else begin
      req_q      <= req_i;
      pending_q  <= pending_d;
      valid_q    <= valid_d;
      code_q     <= code_d;
      lost_q     <= lost_d;
      drop_cnt_q <= drop_cnt_d;
      state_q    <= state_d;
    end
  end

`ifdef REQ_ENC_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  assign valid_o       = valid_q;
  assign code_o        = code_q;
  assign any_pending_o = |pending_q;
  assign lost_o        = lost_q;
  assign drop_cnt_o    = drop_cnt_q;

endmodule
